// File: rtl/arb_que_ctrl.sv
// Round-robin arbiter feeding an external queue, with occupancy tracking,
// downstream pop handshake and a one-cycle flush (clear) sequence.
module arb_que_ctrl #(
  parameter int unsigned NBITS = 8,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*NBITS-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  flush,
  output logic                  en,
  output logic [NBITS-1:0]      que_in,
  output logic                  dec,
  output logic                  clear,
  output logic [3:0]            count_in,
  input  logic [NBITS-1:0]      que_out,
  output logic                  out_valid,
  output logic [NBITS-1:0]      out_data,
  input  logic                  out_ready
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StActive, StFlush} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q, cnt_d;
  logic [PtrW-1:0]   ptr_q, ptr_nxt;
  logic [PtrW-1:0]   winner;
  logic              any_valid;
  logic              push, pop;
  int unsigned       idx;

  // Search from ptr upward with wrap-around; first valid requester wins.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        winner    = PtrW'(idx);
      end
    end
  end

  assign out_valid = (cnt_q != 4'd0) && (state_q != StFlush);
  assign out_data  = out_valid ? que_out : '0;
  assign pop       = out_valid && out_ready;
  assign dec       = pop;
  assign clear     = (state_q == StFlush);
  assign count_in  = cnt_q;

  // nRST gating keeps grant outputs quiet while reset is held.
  assign push = nRST && any_valid && (state_q != StFlush) && !flush &&
                ((cnt_q < 4'(DEPTH)) || pop);

  assign en        = push;
  assign req_ready = push ? (NREQ'(1) << winner) : '0;
  assign que_in    = push ? req_data[32'(winner)*NBITS +: NBITS] : '0;

  assign ptr_nxt = (winner == PtrW'(NREQ - 1)) ? '0 : winner + PtrW'(1);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 4'd1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      ptr_q   <= '0;
    end else if (state_q == StFlush) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        ptr_q <= ptr_nxt;
      end
      if (flush) begin
        state_q <= StFlush;
      end else begin
        state_q <= (cnt_d == 4'd0) ? StIdle : StActive;
      end
    end
  end

endmodule

// File: tb/tb_arb_que_ctrl.sv
// Randomised and directed bench for arb_que_ctrl: cycle-level reference model
// plus a data scoreboard drained by an independent monitor.
module tb_arb_que_ctrl;

  localparam int NBITS = 8;
  localparam int NREQ  = 4;
  localparam int DEPTH = 8;

  logic                  CLK;
  logic                  nRST;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*NBITS-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  flush;
  logic                  en;
  logic [NBITS-1:0]      que_in;
  logic                  dec;
  logic                  clear;
  logic [3:0]            count_in;
  logic [NBITS-1:0]      que_out;
  logic                  out_valid;
  logic [NBITS-1:0]      out_data;
  logic                  out_ready;

  arb_que_ctrl #(.NBITS(NBITS), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .flush     (flush),
    .en        (en),
    .que_in    (que_in),
    .dec       (dec),
    .clear     (clear),
    .count_in  (count_in),
    .que_out   (que_out),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Environment queue storage driven by the DUT strobes.
  logic [NBITS-1:0] mem [16];
  logic [3:0]       rd_p, wr_p;
  assign que_out = mem[rd_p];

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_p <= '0;
      wr_p <= '0;
    end else if (clear) begin
      rd_p <= '0;
      wr_p <= '0;
    end else begin
      if (dec) rd_p <= rd_p + 4'd1;
      if (en) begin
        mem[wr_p] <= que_in;
        wr_p      <= wr_p + 4'd1;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int               m_cnt;
  int               m_ptr;
  bit               m_fl;
  logic [NBITS-1:0] sb_q[$];

  // Monitor: every accepted downstream entry must match the oldest expected push.
  always @(negedge CLK) begin
    if (nRST && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("pop_on_empty_scoreboard", 32'(out_data), 32'hxxxx_xxxx);
      end else begin
        chk("out_data_order", 32'(out_data), 32'(sb_q.pop_front()));
      end
    end
  end

  // One clock cycle: check outputs mid-cycle against the model, then advance.
  task automatic cyc();
    bit               any, ov, pp, ps;
    int               w;
    logic [NREQ-1:0]  exp_rr;
    logic [NBITS-1:0] exp_qi;
    @(negedge CLK);
    ov  = (m_cnt > 0) && !m_fl;
    pp  = ov && out_ready;
    any = 1'b0;
    w   = 0;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (!any && req_valid[i]) begin
        any = 1'b1;
        w   = i;
      end
    end
    ps     = any && !m_fl && !flush && ((m_cnt < DEPTH) || pp);
    exp_rr = ps ? NREQ'(1 << w) : '0;
    exp_qi = ps ? req_data[w*NBITS +: NBITS] : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rr));
    chk("en", 32'(en), 32'(ps));
    chk("que_in", 32'(que_in), 32'(exp_qi));
    chk("dec", 32'(dec), 32'(pp));
    chk("clear", 32'(clear), 32'(m_fl));
    chk("out_valid", 32'(out_valid), 32'(ov));
    chk("out_data", 32'(out_data), ov ? 32'(que_out) : 32'd0);
    chk("count_in", 32'(count_in), 32'(m_cnt));
    if (m_fl) begin
      m_cnt = 0;
      m_fl  = 1'b0;
      sb_q.delete();
    end else begin
      m_cnt = m_cnt + int'(ps) - int'(pp);
      if (ps) begin
        m_ptr = (w + 1) % NREQ;
        sb_q.push_back(exp_qi);
      end
      m_fl = flush;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NREQ; i++) req_data[i*NBITS +: NBITS] = NBITS'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_en"}, 32'(en), 32'd0);
    chk({tag, "_dec"}, 32'(dec), 32'd0);
    chk({tag, "_clear"}, 32'(clear), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_que_in"}, 32'(que_in), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_count_in"}, 32'(count_in), 32'd0);
  endtask

  // Reset dropped between edges; called at posedge+1.
  task automatic reset_mid();
    #2 nRST = 1'b0;
    #1 chk_all_zero("rst_async");
    m_cnt = 0;
    m_ptr = 0;
    m_fl  = 1'b0;
    sb_q.delete();
    @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    nRST      = 1'b0;
    req_valid = '0;
    req_data  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    m_cnt     = 0;
    m_ptr     = 0;
    m_fl      = 1'b0;
    req_valid = '1;
    #3 chk_all_zero("reset");
    @(posedge CLK);
    #1 nRST = 1'b1;

    // Round robin: all valid, no pops -> grants 0,1,2,3.
    for (int c = 0; c < 4; c++) begin
      rand_data();
      cyc();
    end
    chk("rr_count", 32'(count_in), 32'd4);

    // Fill with requester 2 only.
    do_flush();
    req_valid = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      rand_data();
      cyc();
    end
    chk("full_count", 32'(count_in), 32'd8);
    chk("full_no_grant", 32'(req_ready), 32'd0);

    // Full with simultaneous pop.
    req_valid = 4'b0010;
    out_ready = 1'b1;
    rand_data();
    cyc();
    chk("full_pop_count", 32'(count_in), 32'd8);

    // Empty: no bypass of same-cycle push.
    out_ready = 1'b0;
    req_valid = '0;
    do_flush();
    req_valid = 4'b0001;
    req_data  = '0;
    req_data[7:0] = 8'hA5;
    out_ready = 1'b1;
    cyc();
    req_valid = '0;
    chk("empty_next_valid", 32'(out_valid), 32'd1);
    chk("empty_next_data", 32'(out_data), 32'hA5);
    cyc();

    // Flush at cnt=5 with all requesters valid.
    out_ready = 1'b0;
    req_valid = '1;
    while (m_cnt < 5) begin
      rand_data();
      cyc();
    end
    do_flush();
    chk("flush_count", 32'(count_in), 32'd0);

    // Reset mid-operation at cnt=3.
    while (m_cnt < 3) begin
      rand_data();
      cyc();
    end
    reset_mid();
    chk("rst_release_count", 32'(count_in), 32'd0);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      req_valid = NREQ'($urandom);
      rand_data();
      out_ready = ($urandom_range(0, 9) < 5);
      flush     = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 599) == 0) begin
        reset_mid();
      end else begin
        cyc();
      end
    end
    flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
